// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator: pixel counters, sync/blank qualifiers,
// frame strobes and a frame-divided animation phase, all zero-skew registered.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int ANIM_DIV  = 8,
  parameter int ANIM_BITS = 2
) (
  input  logic                 vga_clk,
  input  logic                 reset_n,
  output logic [9:0]           DrawX,
  output logic [9:0]           DrawY,
  output logic                 hs,
  output logic                 vs,
  output logic                 blank,
  output logic                 frame_start,
  output logic                 vblank_tick,
  output logic [ANIM_BITS-1:0] anim_phase
);

  localparam logic [9:0] H_TOTAL  = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP);
  localparam logic [9:0] V_TOTAL  = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [7:0] DIV_LAST = 8'(ANIM_DIV - 1);

  function automatic logic in_range(input logic [9:0] v, input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  logic [9:0] x_p0;
  logic [9:0] y_p0;
  logic       hs_p0;
  logic       vs_p0;
  logic       blank_p0;
  logic       fs_p0;
  logic       tick_p0;
  logic [7:0] frame_div;

  // Stage p0: next counter values and their decode; out-of-range counts wrap to 0.
  always_comb begin
    x_p0 = DrawX + 10'd1;
    y_p0 = DrawY;
    if (DrawX >= H_TOTAL - 10'd1) begin
      x_p0 = '0;
      if (DrawY >= V_TOTAL - 10'd1) y_p0 = '0;
      else                          y_p0 = DrawY + 10'd1;
    end else if (DrawY >= V_TOTAL) begin
      y_p0 = '0;
    end
    hs_p0    = !in_range(x_p0, HS_START, HS_END);
    vs_p0    = !in_range(y_p0, VS_START, VS_END);
    blank_p0 = (x_p0 < H_VIS) && (y_p0 < V_VIS);
    fs_p0    = (x_p0 == 10'd0) && (y_p0 == 10'd0);
    tick_p0  = (x_p0 == 10'd0) && (y_p0 == V_VIS);
  end

  // Stage p1: registered outputs aligned with the counter values they describe.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DrawX       <= '0;
      DrawY       <= '0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b0;
      frame_start <= 1'b0;
      vblank_tick <= 1'b0;
      frame_div   <= '0;
      anim_phase  <= '0;
    end else begin
      DrawX       <= x_p0;
      DrawY       <= y_p0;
      hs          <= hs_p0;
      vs          <= vs_p0;
      blank       <= blank_p0;
      frame_start <= fs_p0;
      vblank_tick <= tick_p0;
      if (tick_p0) begin
        if (frame_div >= DIV_LAST) begin
          frame_div  <= '0;
          anim_phase <= anim_phase + ANIM_BITS'(1);
        end else begin
          frame_div  <= frame_div + 8'd1;
        end
      end
    end
  end

endmodule
